// File: rtl/capture_bank_scheduler_if.sv
// Capture/render bus between the sample path, the scheduler and the ping-pong BRAM write port.
// master drives samples and frame sync; slave is the scheduler.
interface capture_bank_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
);
  logic              enable;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              frame_sync;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_bank;
  logic              swap_pulse;
  logic [1:0]        state;
  logic [7:0]        skip_count;

  modport master (
    output enable, sample_valid, sample_data, frame_sync,
    input  wr_en, wr_bank, wr_addr, wr_data, rd_bank, swap_pulse, state, skip_count
  );

  modport slave (
    input  enable, sample_valid, sample_data, frame_sync,
    output wr_en, wr_bank, wr_addr, wr_data, rd_bank, swap_pulse, state, skip_count
  );
endinterface

// File: rtl/capture_bank_scheduler.sv
// Ping-pong capture scheduler: arms a rising-edge trigger, fills the bank the renderer is not
// reading, and swaps banks on frame sync. Define SCOPE_AUTO_TRIG_EN for the ARMED-state auto trigger.
module capture_bank_scheduler #(
  parameter int                DEPTH        = 1024,
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 12,
  parameter logic [DATA_W-1:0] TRIG_LEVEL   = DATA_W'('h800),
  parameter int                AUTO_TIMEOUT = 4096
) (
  input logic                     CLK104MHZ,
  input logic                     rst,
  capture_bank_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FULL    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [DATA_W-1:0] prev_q;
  logic              rd_bank_q;
  logic              swap_q, swap_d;
  logic [7:0]        skip_q;
  logic              level_trig;
  logic              auto_trig;

  assign level_trig = bus.sample_valid && (prev_q < TRIG_LEVEL) && (bus.sample_data >= TRIG_LEVEL);

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] timeout_q;

  // The strobe that would make the count reach AUTO_TIMEOUT is itself the forced trigger.
  assign auto_trig = (state_q == ARMED) && bus.sample_valid &&
                     (timeout_q == TO_W'(AUTO_TIMEOUT - 1));

  always_ff @(posedge CLK104MHZ) begin
    if (rst || state_q != ARMED || state_d != ARMED) begin
      timeout_q <= '0;
    end else if (bus.sample_valid) begin
      timeout_q <= timeout_q + TO_W'(1);
    end
  end
`else
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    next_addr_d = next_addr_q;
    swap_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (level_trig || auto_trig) begin
          state_d     = CAPTURE;
          wr_en_d     = 1'b1;
          wr_addr_d   = '0;
          wr_data_d   = bus.sample_data;
          next_addr_d = ADDR_W'(1);
        end
      end
      CAPTURE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (bus.sample_valid) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = next_addr_q;
          wr_data_d   = bus.sample_data;
          next_addr_d = next_addr_q + ADDR_W'(1);
          if (next_addr_q == LAST_ADDR) state_d = FULL;
        end
      end
      FULL: begin
        // A held record is only released by frame sync, even when capture is disabled.
        if (bus.frame_sync) begin
          swap_d  = 1'b1;
          state_d = bus.enable ? ARMED : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK104MHZ) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      next_addr_q <= '0;
      prev_q      <= '0;
      rd_bank_q   <= 1'b0;
      swap_q      <= 1'b0;
      skip_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      next_addr_q <= next_addr_d;
      swap_q      <= swap_d;
      if (bus.sample_valid) prev_q <= bus.sample_data;
      if (swap_d) rd_bank_q <= ~rd_bank_q;
      // Frame sync outside FULL means the renderer redraws an old record.
      if (bus.frame_sync && state_q != FULL && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
    end
  end

  assign bus.state      = state_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.wr_bank    = ~rd_bank_q;
  assign bus.swap_pulse = swap_q;
  assign bus.skip_count = skip_q;

endmodule

// File: tb/tb_capture_bank_scheduler.sv
// Randomized scoreboard bench for capture_bank_scheduler; the reference model follows the
// record-level rules (armed / filling record n / holding) and is compiled with the same macro.
module tb_capture_bank_scheduler;
  localparam int DEPTH        = 1024;
  localparam int TRIG         = 'h800;
  localparam int AUTO_TIMEOUT = 4096;
`ifdef SCOPE_AUTO_TRIG_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_FULL = 3;

  logic CLK104MHZ = 1'b0;
  logic rst;
  always #5 CLK104MHZ = ~CLK104MHZ;

  capture_bank_scheduler_if #(.ADDR_W(10), .DATA_W(12)) bus ();

  capture_bank_scheduler dut (
    .CLK104MHZ (CLK104MHZ),
    .rst       (rst),
    .bus       (bus)
  );

  // Expected per-cycle status: state, rd_bank, wr_bank, swap, wr_en, skip, wr_addr, wr_data.
  logic [35:0] status_q[$];
  // Expected writes: bank, addr, data.
  logic [22:0] write_q[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int          m_mode  = M_IDLE;
  int          m_count = 0;
  int          m_wait  = 0;
  int          m_skip  = 0;
  bit          m_rd    = 1'b0;
  int          m_prev  = 0;
  int          m_addr  = 0;
  int          m_data  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_write(input int addr, input int data);
    write_q.push_back({~m_rd, 10'(addr), 12'(data)});
    m_addr = addr;
    m_data = data;
  endtask

  task automatic model_step(input bit r, input bit en, input bit sv, input int sd, input bit fs);
    bit wrote   = 1'b0;
    bit swapped = 1'b0;
    bit rising;
    if (r) begin
      m_mode = M_IDLE; m_count = 0; m_wait = 0; m_skip = 0;
      m_rd = 1'b0; m_prev = 0; m_addr = 0; m_data = 0;
    end else begin
      rising = sv && (m_prev < TRIG) && (sd >= TRIG);
      if (fs && m_mode != M_FULL && m_skip < 255) m_skip++;
      case (m_mode)
        M_IDLE: if (en) begin m_mode = M_ARMED; m_wait = 0; end
        M_ARMED: begin
          if (!en) m_mode = M_IDLE;
          else if (sv) begin
            m_wait++;
            if (rising || (AUTO_EN && m_wait == AUTO_TIMEOUT)) begin
              model_write(0, sd);
              wrote = 1'b1; m_count = 1; m_mode = M_CAPTURE;
            end
          end
        end
        M_CAPTURE: begin
          if (!en) m_mode = M_IDLE;
          else if (sv) begin
            model_write(m_count, sd);
            wrote = 1'b1; m_count++;
            if (m_count == DEPTH) m_mode = M_FULL;
          end
        end
        default: begin
          if (fs) begin
            m_rd = ~m_rd; swapped = 1'b1; m_wait = 0;
            m_mode = en ? M_ARMED : M_IDLE;
          end
        end
      endcase
      if (sv) m_prev = sd;
    end
    status_q.push_back({2'(m_mode), m_rd, ~m_rd, swapped, wrote, 8'(m_skip), 10'(m_addr), 12'(m_data)});
  endtask

  // Inputs change 3 time units after the edge; the model predicts the state after the next edge.
  task automatic drive(input bit r, input bit en, input bit sv, input int sd, input bit fs);
    @(posedge CLK104MHZ);
    #3;
    rst              = r;
    bus.enable       = en;
    bus.sample_valid = sv;
    bus.sample_data  = 12'(sd);
    bus.frame_sync   = fs;
    model_step(r, en, sv, sd, fs);
  endtask

  task automatic sample(input bit en, input int sd, input int gap);
    drive(1'b0, en, 1'b1, sd, 1'b0);
    for (int k = 1; k < gap; k++) drive(1'b0, en, 1'b0, 0, 1'b0);
  endtask

  // Monitor: one status record per cycle, one write record per DUT write strobe.
  initial begin
    logic [35:0] exp_s;
    logic [22:0] exp_w;
    forever begin
      @(posedge CLK104MHZ);
      #1;
      if (status_q.size() != 0) begin
        exp_s = status_q.pop_front();
        check("status", {bus.state, bus.rd_bank, bus.wr_bank, bus.swap_pulse, bus.wr_en,
                         bus.skip_count, bus.wr_addr, bus.wr_data}, 64'(exp_s));
      end
      if (bus.wr_en === 1'b1) begin
        if (write_q.size() == 0) begin
          n_total++;
          $display("FAIL write_unexpected: got addr %0h data %0h, expected no write (t=%0t)",
                   bus.wr_addr, bus.wr_data, $time);
        end else begin
          exp_w = write_q.pop_front();
          check("write", {bus.wr_bank, bus.wr_addr, bus.wr_data}, 64'(exp_w));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.sample_valid = 1'b0; bus.sample_data = '0; bus.frame_sync = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Ramp with a sample every 4 cycles: triggers at 0x800, fills 0x800..0xBFF, then holds.
    for (int i = 0; i < 4096; i++) sample(1'b1, i, 4);

    // Swap, then non-crossing samples must not write.
    drive(1'b0, 1'b1, 1'b0, 0, 1'b1);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++) sample(1'b1, int'($urandom_range(4095, 2048)), 1 + int'($urandom_range(2, 0)));

    // Constant level above threshold: only the auto trigger can start a record.
    for (int i = 0; i < 5000; i++) sample(1'b1, 'h900, 1);

    // Fresh start: capture with a frame sync at address 500.
    repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    sample(1'b1, 'h100, 2);
    sample(1'b1, 'h900, 2);
    while (m_mode == M_CAPTURE) begin
      sample(1'b1, int'($urandom_range(4095, 0)), 2);
      if (m_count == 500) drive(1'b0, 1'b1, 1'b0, 0, 1'b1);
    end

    // Frame sync together with a sample while holding: swap, no write, prev updated to 0x100.
    drive(1'b0, 1'b1, 1'b1, 'h100, 1'b1);
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 1'b0, 0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    end
    sample(1'b1, 'h900, 2);

    // Reset in the middle of a record.
    while (m_mode == M_CAPTURE && m_count < 600) sample(1'b1, int'($urandom_range(4095, 0)), 1);
    drive(1'b1, 1'b1, 1'b1, 'h123, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Disable in the middle of a record, with a sample in the same cycle.
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0);
    sample(1'b1, 'h100, 1);
    sample(1'b1, 'h900, 1);
    while (m_mode == M_CAPTURE && m_count < 600) sample(1'b1, int'($urandom_range(4095, 0)), 1);
    drive(1'b0, 1'b0, 1'b1, 'h777, 1'b0);
    for (int i = 0; i < 20; i++) sample(1'b0, int'($urandom_range(4095, 0)), 2);

    // Random traffic: mostly enabled, dense samples, occasional frame sync.
    for (int i = 0; i < 6000; i++) begin
      drive(1'b0, ($urandom_range(199, 0) != 0), $urandom_range(1, 0) == 1,
            int'($urandom_range(4095, 0)), $urandom_range(299, 0) == 0);
    end

    repeat (3) drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge CLK104MHZ);
    #2;
    check("queues_drained", 64'(status_q.size() + write_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
